dpram_fifo_ctrl: RTL
====================

Name: dpram_fifo_ctrl

Overview:
Synchronous FIFO controller that drives a separate two-port RAM. Port A of the RAM is the write side; port B is the read side, with a 1-cycle registered read. The controller turns valid/ready streams on both sides into RAM addresses and write strobes. It hides the RAM read latency behind a 2-entry output skid buffer, so a producer can stream into the RAM and a consumer can drain it at 1 word/cycle without bubbles.

Parameters:
DATA_WIDTH, 8, word width; must match the RAM data width.
ADDR_WIDTH, 4, RAM address width; RAM depth DEPTH = 2**ADDR_WIDTH.

Ports:
clk  in  1  single clock; all state updates on its rising edge
rst_n  in  1  asynchronous active-low reset
wr_valid  in  1  producer has a word
wr_ready  out  1  controller accepts the word
wr_data  in  DATA_WIDTH  producer word
rd_valid  out  1  rd_data holds a valid word
rd_ready  in  1  consumer takes the word
rd_data  out  DATA_WIDTH  head-of-FIFO word (registered)
count  out  ADDR_WIDTH+2  total words held: RAM + in-flight + skid
ram_we_a  out  1  RAM port A write enable
ram_addr_a  out  ADDR_WIDTH  RAM port A address (write pointer)
ram_din_a  out  DATA_WIDTH  RAM port A write data
ram_we_b  out  1  RAM port B write enable; constant 0
ram_addr_b  out  ADDR_WIDTH  RAM port B address (read pointer)
ram_dout_b  in  DATA_WIDTH  RAM port B registered read data

Behaviour:
- Reset (rst_n low, takes effect asynchronously):
  - wptr, rptr, ram_cnt, inflight, skid count and skid entries clear to 0.
  - rd_valid=0, rd_data=0, count=0, wr_ready=0, ram_we_a=0.
  - RAM contents are not cleared and are don't-care.
  - Reset mid-stream discards all held words; an in-flight RAM read is ignored.
- Write side:
  - wr_ready = rst_n && (ram_cnt < DEPTH).
  - push = wr_valid && wr_ready.
  - ram_we_a = push, ram_addr_a = wptr, ram_din_a = wr_data, all combinational.
  - On push, wptr increments modulo DEPTH (natural wrap).
- Read issue:
  - pop = rd_valid && rd_ready.
  - issue = (ram_cnt > 0) && (skid_cnt + inflight - pop < 2).
  - ram_addr_b = rptr at all times.
  - On issue, rptr increments modulo DEPTH and inflight is set for the next cycle.
  - The RAM slot is freed at issue: a port-A write to the same address at the same edge is safe, because port B returns the old word.
- Data capture and latency:
  - When inflight=1, ram_dout_b is written into the skid buffer at the cycle's end.
  - Write handshake in cycle 0 -> issue in cycle 1 -> inflight in cycle 2 -> rd_valid=1 in cycle 3, given an empty FIFO.
- Skid buffer:
  - 2-entry FIFO; rd_data = entry 0 (registered); rd_valid = (skid_cnt > 0).
  - A simultaneous capture and pop shifts entry 1 to entry 0 and loads the new word into the vacated slot. Word order is preserved.
- Counters:
  - ram_cnt' = ram_cnt + push - issue, range 0..DEPTH.
  - count = ram_cnt + inflight + skid_cnt, maximum DEPTH+2.
- Full:
  - wr_ready=0 when ram_cnt == DEPTH.
  - A push and an issue in the same cycle at full is impossible, since push requires ram_cnt < DEPTH. ram_cnt drops before wr_ready reasserts.
- Empty: with ram_cnt == 0 there is no issue; ram_addr_b still drives rptr.
- Simultaneous push + pop at steady state: throughput is 1 word/cycle, and count stays constant.
- Overflow/underflow: impossible by construction. Assertions flag a push when ram_cnt == DEPTH and a pop when skid_cnt == 0.

Decomposition:
- Shared package (fifo_pkg):
  - DEPTH = 1 << ADDR_WIDTH.
  - CNT_W = ADDR_WIDTH + 2.
  - SKID_DEPTH = 2.
- Sub-module out_skid_buf:
  - 2-entry registered buffer with load/pop and skid_cnt output.
  - Parameterised by DATA_WIDTH; same clk/rst_n.
- Top-level dpram_fifo_ctrl:
  - Holds the pointers, ram_cnt, inflight and issue logic.
  - Bench instantiates the RAM alongside it.

Test Plan:
1. Reset, then write 0x11, rd_ready=1 -> ram_we_a=1 with ram_addr_a=0 in cycle 0; rd_valid=1 with rd_data=0x11 in cycle 3; count returns to 0 after the pop.
2. rd_ready=0, write 0x00..0x11 (18 words) -> 16 in RAM plus 2 in skid; wr_ready=0 once ram_cnt=16; count=18; the 19th write is stalled.
3. From full, assert rd_ready=1 and keep writing -> output sequence 0x00,0x01,... with no gaps; wptr and rptr wrap 15->0; data intact across the wrap.
4. Continuous push+pop with an incrementing pattern for 100 cycles -> one pop per cycle after the 3-cycle fill; count constant at its steady value; no reordering.
5. Random wr_valid/rd_ready at 50% for 2000 cycles -> scoreboard matches in order; count always equals the model; never exceeds 18.
6. Fill 5 words, assert rst_n=0 mid-stream for one cycle -> rd_valid=0, count=0, wr_ready=0 immediately; after release, a fresh write 0xA5 is read back as the first word.

Source files
------------

// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared sizing helpers for the dual-port RAM FIFO controller
// Provides depth and counter-width helpers derived from the RAM address width,
// and the fixed depth of the output skid buffer. No ports.
package fifo_pkg;

    localparam int SKID_DEPTH = 2;

    // RAM depth for a given address width.
    function automatic int depth_of(input int addr_width);
        return 1 << addr_width;
    endfunction

    // Width of the total-occupancy counter: holds DEPTH + SKID_DEPTH.
    function automatic int cnt_width(input int addr_width);
        return addr_width + 2;
    endfunction

endpackage

// File: rtl/dpram_fifo_ctrl_if.sv
// rtl/dpram_fifo_ctrl_if.sv - producer/consumer stream bundle of the FIFO controller
// Signals: wr_valid/wr_ready/wr_data (producer stream), rd_valid/rd_ready/rd_data
// (consumer stream), count (total words held).
// master: producer/consumer side. slave: controller side.
interface dpram_fifo_ctrl_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
);
    logic                  wr_valid;
    logic                  wr_ready;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  rd_valid;
    logic                  rd_ready;
    logic [DATA_WIDTH-1:0] rd_data;
    logic [ADDR_WIDTH+1:0] count;

    modport master (
        output wr_valid, wr_data, rd_ready,
        input  wr_ready, rd_valid, rd_data, count
    );

    modport slave (
        input  wr_valid, wr_data, rd_ready,
        output wr_ready, rd_valid, rd_data, count
    );
endinterface

// File: rtl/dpram_fifo_ctrl_out_skid_buf.sv
// rtl/dpram_fifo_ctrl_out_skid_buf.sv - 2-entry registered output buffer behind the RAM read port
// Ports: clk, rst_n (async active-low); load/load_data capture a word returned by
// the RAM; pop removes the head; head is entry 0 (registered); cnt is occupancy 0..2.
module out_skid_buf
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] head,
    output logic [1:0]            cnt
);

    logic [DATA_WIDTH-1:0] entry0;
    logic [DATA_WIDTH-1:0] entry1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            entry0 <= '0;
            entry1 <= '0;
            cnt    <= 2'd0;
        end else begin
            case ({load, pop})
                2'b10: begin
                    if (cnt == 2'd0) entry0 <= load_data;
                    else             entry1 <= load_data;
                    cnt <= cnt + 2'd1;
                end
                2'b01: begin
                    entry0 <= entry1;
                    cnt    <= cnt - 2'd1;
                end
                2'b11: begin
                    // Occupancy unchanged; the new word lands behind whatever remains.
                    if (cnt == 2'd1) begin
                        entry0 <= load_data;
                    end else begin
                        entry0 <= entry1;
                        entry1 <= load_data;
                    end
                end
                default: ;
            endcase
        end
    end

    assign head = entry0;

    a_no_skid_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(load && !pop && (int'(cnt) == SKID_DEPTH)));

endmodule

// File: rtl/dpram_fifo_ctrl.sv
// rtl/dpram_fifo_ctrl.sv - FIFO controller streaming through an external two-port RAM
// Ports: clk, rst_n (async active-low); bus (slave) carries the write/read streams
// and count; ram_we_a/ram_addr_a/ram_din_a drive the RAM write port;
// ram_we_b (tied 0)/ram_addr_b/ram_dout_b connect the registered RAM read port.
module dpram_fifo_ctrl
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    dpram_fifo_ctrl_if.slave      bus,
    output logic                  ram_we_a,
    output logic [ADDR_WIDTH-1:0] ram_addr_a,
    output logic [DATA_WIDTH-1:0] ram_din_a,
    output logic                  ram_we_b,
    output logic [ADDR_WIDTH-1:0] ram_addr_b,
    input  logic [DATA_WIDTH-1:0] ram_dout_b
);

    localparam int DEPTH = depth_of(ADDR_WIDTH);
    localparam int CNT_W = cnt_width(ADDR_WIDTH);
    localparam logic [ADDR_WIDTH:0] DEPTH_V = DEPTH[ADDR_WIDTH:0];

    logic [ADDR_WIDTH-1:0] wptr;
    logic [ADDR_WIDTH-1:0] rptr;
    logic [ADDR_WIDTH:0]   ram_cnt;
    logic                  inflight;
    logic [1:0]            skid_cnt;
    logic [2:0]            occ;
    logic                  push;
    logic                  pop;
    logic                  issue;

    assign bus.wr_ready = rst_n && (ram_cnt < DEPTH_V);
    assign push         = bus.wr_valid && bus.wr_ready;
    assign pop          = bus.rd_valid && bus.rd_ready;

    // Words already committed to the skid buffer (held or returning next edge).
    // A read may only be issued if its word will still find a free slot after
    // this cycle's pop, so the buffer can never overflow.
    assign occ   = {1'b0, skid_cnt} + {2'b00, inflight};
    assign issue = (ram_cnt != '0) && (occ < (3'd2 + {2'b00, pop}));

    assign ram_we_a   = push;
    assign ram_addr_a = wptr;
    assign ram_din_a  = bus.wr_data;
    assign ram_we_b   = 1'b0;
    assign ram_addr_b = rptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr     <= '0;
            rptr     <= '0;
            ram_cnt  <= '0;
            inflight <= 1'b0;
        end else begin
            if (push)  wptr <= wptr + ADDR_WIDTH'(1);
            if (issue) rptr <= rptr + ADDR_WIDTH'(1);
            case ({push, issue})
                2'b10:   ram_cnt <= ram_cnt + (ADDR_WIDTH+1)'(1);
                2'b01:   ram_cnt <= ram_cnt - (ADDR_WIDTH+1)'(1);
                default: ram_cnt <= ram_cnt;
            endcase
            inflight <= issue;
        end
    end

    out_skid_buf #(.DATA_WIDTH(DATA_WIDTH)) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (inflight),
        .load_data (ram_dout_b),
        .pop       (pop),
        .head      (bus.rd_data),
        .cnt       (skid_cnt)
    );

    assign bus.rd_valid = (skid_cnt != 2'd0);
    assign bus.count    = CNT_W'(ram_cnt) + CNT_W'(inflight) + CNT_W'(skid_cnt);

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && (ram_cnt == DEPTH_V)));
    a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(pop && (skid_cnt == 2'd0)));

endmodule
